// File: rtl/go_board_pkg.sv
// Shared Go Board constants and types for the switch/LED blocks.
package go_board_pkg;

  localparam int unsigned NUM_SWITCHES  = 4;
  localparam int unsigned CLK_HZ        = 25_000_000;
  localparam int unsigned DEBOUNCE_10MS = 250000;

  typedef logic [NUM_SWITCHES-1:0] sw_vec_t;

  // Counter width for a debounce limit; a limit of 1 still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/switch_toggle_leds_debounce_filter.sv
// Per-switch synchroniser plus debounce counter producing a clean level.
module debounce_filter
  import go_board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_10MS,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Level
);

  localparam int unsigned    CW      = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] r_Sync;
  logic [CW-1:0]          r_Count;
  logic                   r_Db;
  logic                   w_Sync;

  assign w_Sync = r_Sync[SYNC_STAGES-1];

  // Shift the asynchronous switch level through the synchroniser chain.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sync <= '0;
    end else begin
      r_Sync <= {r_Sync[SYNC_STAGES-2:0], i_Raw};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_LIMIT consecutive cycles.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Count <= '0;
      r_Db    <= 1'b0;
    end else if (w_Sync != r_Db) begin
      if (r_Count == CNT_MAX) begin
        r_Db    <= w_Sync;
        r_Count <= '0;
      end else begin
        r_Count <= r_Count + 1'b1;
      end
    end else begin
      r_Count <= '0;
    end
  end

  assign o_Level = r_Db;

endmodule

// File: rtl/switch_toggle_leds.sv
// Debounces the four Go Board switches and toggles each LED once per clean release.
module switch_toggle_leds
  import go_board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_10MS,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic    i_Clk,
  input  logic    i_Rst_L,
  input  logic    i_Switch_1,
  input  logic    i_Switch_2,
  input  logic    i_Switch_3,
  input  logic    i_Switch_4,
  output logic    o_LED_1,
  output logic    o_LED_2,
  output logic    o_LED_3,
  output logic    o_LED_4,
  output sw_vec_t o_Switch_Db,
  output sw_vec_t o_Release_Pulse
);

  sw_vec_t w_Raw;
  sw_vec_t w_Db;
  sw_vec_t r_Db_q;
  sw_vec_t r_LED;

  assign w_Raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_chan
    debounce_filter #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_filter (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Raw   (w_Raw[g]),
      .o_Level (w_Db[g])
    );
  end

  // Delayed copy of the debounced levels for falling-edge detection.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Db_q <= '0;
    end else begin
      r_Db_q <= w_Db;
    end
  end

  // Release strobe decoded purely from registered levels; presses give no strobe.
  assign o_Release_Pulse = r_Db_q & ~w_Db;

  // Flip every LED whose channel strobes this cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_LED <= '0;
    end else begin
      r_LED <= r_LED ^ o_Release_Pulse;
    end
  end

  assign o_Switch_Db = w_Db;
  assign o_LED_1     = r_LED[0];
  assign o_LED_2     = r_LED[1];
  assign o_LED_3     = r_LED[2];
  assign o_LED_4     = r_LED[3];

endmodule

// File: tb/tb_switch_toggle_leds.sv
// Scoreboard bench for switch_toggle_leds with a window-based debounce reference.
module tb_switch_toggle_leds;
  import go_board_pkg::*;

  localparam int LIMIT = 4;
  localparam int SYNC  = 2;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
  logic    led1, led2, led3, led4;
  sw_vec_t db, pulse;

  int checks = 0;
  int errors = 0;

  switch_toggle_leds #(
    .DEBOUNCE_LIMIT (LIMIT),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .i_Clk           (clk),
    .i_Rst_L         (rst_n),
    .i_Switch_1      (sw1),
    .i_Switch_2      (sw2),
    .i_Switch_3      (sw3),
    .i_Switch_4      (sw4),
    .o_LED_1         (led1),
    .o_LED_2         (led2),
    .o_LED_3         (led3),
    .o_LED_4         (led4),
    .o_Switch_Db     (db),
    .o_Release_Pulse (pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic sw_vec_t leds();
    return {led4, led3, led2, led1};
  endfunction

  // ---------------- reference model ----------------
  // A channel's clean level flips when the synchronised raw value (raw delayed by
  // SYNC edges) has been the opposite level for the last LIMIT edges.
  typedef struct { int cyc; sw_vec_t mask; } exp_t;
  exp_t    exp_q[$];
  sw_vec_t raw_hist[$];
  sw_vec_t win[$];
  sw_vec_t m_db, m_led, m_pend;
  int      cyc;

  always @(posedge clk or negedge rst_n) begin
    sw_vec_t raw, seen, nxt, rel;
    bit      all_diff;
    if (!rst_n) begin
      raw_hist.delete();
      win.delete();
      exp_q.delete();
      m_db = '0; m_led = '0; m_pend = '0; cyc = 0;
    end else begin
      cyc++;
      raw = {sw4, sw3, sw2, sw1};
      raw_hist.push_back(raw);
      seen = (raw_hist.size() > SYNC) ? raw_hist[raw_hist.size()-1-SYNC] : '0;
      if (raw_hist.size() > SYNC + 1) void'(raw_hist.pop_front());
      win.push_back(seen);
      if (win.size() > LIMIT) void'(win.pop_front());
      m_led = m_led ^ m_pend;
      nxt = m_db;
      if (win.size() == LIMIT) begin
        for (int n = 0; n < NUM_SWITCHES; n++) begin
          all_diff = 1'b1;
          for (int i = 0; i < win.size(); i++)
            if (win[i][n] == m_db[n]) all_diff = 1'b0;
          if (all_diff) nxt[n] = ~m_db[n];
        end
      end
      rel    = m_db & ~nxt;
      m_db   = nxt;
      m_pend = rel;
      if (rel != '0) exp_q.push_back('{cyc, rel});
    end
  end

  // ---------------- monitor ----------------
  sw_vec_t last_pulse = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("switch_db", db, m_db);
      chk("leds", leds(), m_led);
      if (pulse != '0) begin
        last_pulse = pulse;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", pulse, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_mask", pulse, e.mask);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hold [4];

  initial begin
    wait_neg(3);
    chk("reset_db", db, 0);
    chk("reset_pulse", pulse, 0);
    chk("reset_leds", leds(), 0);
    rst_n = 1'b1;

    // Clean press/release on switch 1 with explicit latency checks.
    wait_neg(1);
    sw1 = 1'b1;
    wait_neg(5);
    chk("press_before_N", db[0], 0);
    wait_neg(1);
    chk("press_at_N", db[0], 1);
    chk("press_no_toggle", led1, 0);
    wait_neg(13);
    sw1 = 1'b0;
    wait_neg(10);
    chk("release_toggle", led1, 1);

    // Bounce on switch 2.
    for (int k = 0; k < 4; k++) begin
      sw2 = (k % 2 == 0);
      wait_neg(2);
    end
    sw2 = 1'b0;
    wait_neg(12);
    chk("bounce_led2", led2, 0);

    // Minimum width on switch 3: 4 cycles accepted, 3 rejected.
    sw3 = 1'b1; wait_neg(4); sw3 = 1'b0;
    wait_neg(14);
    chk("minwidth4_led3", led3, 1);
    sw3 = 1'b1; wait_neg(3); sw3 = 1'b0;
    wait_neg(14);
    chk("minwidth3_led3", led3, 1);

    // Simultaneous press/release, twice.
    for (int r = 0; r < 2; r++) begin
      {sw4, sw3, sw2, sw1} = 4'b1111;
      wait_neg(10);
      last_pulse = '0;
      {sw4, sw3, sw2, sw1} = 4'b0000;
      wait_neg(10);
      chk("simul_pulse", last_pulse, 4'b1111);
      chk("simul_leds", leds(), (r == 0) ? 4'b1010 : 4'b0101);
    end

    // Randomised levels with random hold lengths.
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          hold[i] = $urandom_range(1, 9);
          case (i)
            0: sw1 = $urandom_range(0, 1);
            1: sw2 = $urandom_range(0, 1);
            2: sw3 = $urandom_range(0, 1);
            default: sw4 = $urandom_range(0, 1);
          endcase
        end
        hold[i]--;
      end
      wait_neg(1);
    end
    {sw4, sw3, sw2, sw1} = 4'b0000;
    wait_neg(15);

    // Reset mid-count: get LED_1 on, then assert reset while switch 1 is counting.
    if (!led1) begin
      sw1 = 1'b1; wait_neg(10); sw1 = 1'b0; wait_neg(10);
    end
    chk("pre_reset_led1", led1, 1);
    sw1 = 1'b1;
    sw4 = 1'b1;
    wait_neg(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_db", db, 0);
    chk("async_reset_pulse", pulse, 0);
    chk("async_reset_leds", leds(), 0);
    sw1 = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(5);
    chk("held_before_N", db[3], 0);
    wait_neg(1);
    chk("held_at_N", db[3], 1);
    wait_neg(4);
    chk("held_no_toggle", led4, 0);
    sw4 = 1'b0;
    wait_neg(10);
    chk("held_release_toggle", led4, 1);

    wait_neg(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
